pipe_skid_stage: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake and an optional one-entry skid buffer, replacing the fixed-field stall/flush stage registers between CPU pipeline stages. It carries an opaque payload plus a sideband field (e.g. external-interrupt lines) that is zeroed on capture when a qualifier is set. Stall is expressed as backpressure (`out_ready_i` low) rather than a separate stall input. Flush discards all held beats in one cycle.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_stage.sv | 171 +++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: occupancy state encoding and count width.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_pkg;

  // Width of the beats-held count exported by a stage (0..2).
  localparam int PIPE_CNT_W = 2;

  // Stage occupancy: nothing held, output register held, output + skid held.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  // Number of beats held for a given occupancy state.
  function automatic logic [PIPE_CNT_W-1:0] pipe_state_count(input pipe_state_e s);
    case (s)
      PS_BUSY: return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and optional one-entry skid buffer.
// Latency: one cycle; a beat accepted at edge N is presented from cycle N+1, 1 beat/cycle sustained.
// Backpressure: SKID=1 gives a registered in_ready_o (one extra beat absorbed); SKID=0 passes out_ready_i through combinationally.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int SIDE_W = 6,
  parameter int SKID   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_data_i,
  input  logic [SIDE_W-1:0]     in_side_i,
  input  logic                  in_side_clr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [SIDE_W-1:0]     out_side_o,
  output logic [PIPE_CNT_W-1:0] count_o
);

  pipe_state_e       state_q, state_d;
  logic [WIDTH-1:0]  or_data_q, or_data_d;
  logic [SIDE_W-1:0] or_side_q, or_side_d;

  // Skid register contents as seen by the shared output-register path.
  logic [WIDTH-1:0]  sr_data;
  logic [SIDE_W-1:0] sr_side;

  logic              in_fire;
  logic              out_fire;
  logic              sr_load;
  logic [SIDE_W-1:0] cap_side;

  assign out_valid_o = (state_q != PS_EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign cap_side    = in_side_clr_i ? '0 : in_side_i;

  assign out_data_o  = or_data_q;
  assign out_side_o  = or_side_q;
  assign count_o     = pipe_state_count(state_q);

  // Next occupancy and output-register contents; flush wins over any handshake.
  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_side_d = or_side_q;
    sr_load   = 1'b0;

    if (flush_i) begin
      state_d   = PS_EMPTY;
      or_data_d = '0;
      or_side_d = '0;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d   = PS_BUSY;
            or_data_d = in_data_i;
            or_side_d = cap_side;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            // Head leaves while the new beat takes its place.
            or_data_d = in_data_i;
            or_side_d = cap_side;
          end else if (in_fire) begin
            if (SKID != 0) begin
              // Downstream stalled: park the beat behind the head.
              state_d = PS_FULL;
              sr_load = 1'b1;
            end else begin
              // Not reachable without a skid (ready implies out_fire here);
              // kept so the stage never drops an accepted beat.
              or_data_d = in_data_i;
              or_side_d = cap_side;
            end
          end else if (out_fire) begin
            // Drained: payload/sideband keep their last values.
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_d   = PS_BUSY;
            or_data_d = sr_data;
            or_side_d = sr_side;
          end
        end
        default: begin
          state_d   = PS_EMPTY;
          or_data_d = '0;
          or_side_d = '0;
        end
      endcase
    end
  end

  // Occupancy and output register; reset clears immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= PS_EMPTY;
      or_data_q <= '0;
      or_side_q <= '0;
    end else begin
      state_q   <= state_d;
      or_data_q <= or_data_d;
      or_side_q <= or_side_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0]  sr_data_q, sr_data_d;
      logic [SIDE_W-1:0] sr_side_q, sr_side_d;

      // Skid register loads only when a beat arrives behind a stalled head.
      always_comb begin
        sr_data_d = sr_data_q;
        sr_side_d = sr_side_q;
        if (flush_i) begin
          sr_data_d = '0;
          sr_side_d = '0;
        end else if (sr_load) begin
          sr_data_d = in_data_i;
          sr_side_d = cap_side;
        end
      end

      // Skid register storage.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sr_data_q <= '0;
          sr_side_q <= '0;
        end else begin
          sr_data_q <= sr_data_d;
          sr_side_q <= sr_side_d;
        end
      end

      assign sr_data = sr_data_q;
      assign sr_side = sr_side_q;

      // Ready is decoded from state alone, breaking the out_ready_i timing path.
      assign in_ready_o = (state_q != PS_FULL);
    end else begin : g_noskid
      assign sr_data = '0;
      assign sr_side = '0;

      // Without a skid entry the stage can only take a beat if the head leaves.
      assign in_ready_o = ~out_valid_o | out_ready_i;
    end
  endgenerate

  // A full stage must never accept upstream data.
  a_no_fire_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i) !((state_q == PS_FULL) && in_fire)
  );

  // Only the skid variant may ever hold two beats.
  a_full_needs_skid: assert property (
    @(posedge clk_i) disable iff (rst_i) ((SKID != 0) || (state_q != PS_FULL))
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int W = 128;
  localparam int S = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [S-1:0] in_side;
  logic         in_clr;
  logic         out_ready;

  logic         rdy1, vld1, rdy0, vld0;
  logic [W-1:0] dat1, dat0;
  logic [S-1:0] sid1, sid0;
  logic [1:0]   cnt1, cnt0;

  pipe_skid_stage #(.WIDTH(W), .SIDE_W(S), .SKID(1)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
    .in_side_i(in_side), .in_side_clr_i(in_clr),
    .out_valid_o(vld1), .out_ready_i(out_ready), .out_data_o(dat1),
    .out_side_o(sid1), .count_o(cnt1)
  );

  pipe_skid_stage #(.WIDTH(W), .SIDE_W(S), .SKID(0)) u_noskid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
    .in_side_i(in_side), .in_side_clr_i(in_clr),
    .out_valid_o(vld0), .out_ready_i(out_ready), .out_data_o(dat0),
    .out_side_o(sid0), .count_o(cnt0)
  );

  // Reference model: each stage is a FIFO of bounded capacity; the visible
  // payload is the head, or the last beat to leave when drained.
  typedef struct {
    logic [W-1:0] d;
    logic [S-1:0] s;
  } beat_t;

  beat_t q1[$];
  beat_t q0[$];
  beat_t last1, last0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    q1.delete();
    q0.delete();
    last1 = '{d: '0, s: '0};
    last0 = '{d: '0, s: '0};
  endtask

  task automatic check_models();
    beat_t h1, h0;
    logic  er1, er0;
    h1  = (q1.size() > 0) ? q1[0] : last1;
    h0  = (q0.size() > 0) ? q0[0] : last0;
    er1 = (q1.size() < 2);
    er0 = (q0.size() == 0) || out_ready;
    chk("skid.valid", W'(vld1), W'(q1.size() > 0));
    chk("skid.count", W'(cnt1), W'(q1.size()));
    chk("skid.ready", W'(rdy1), W'(er1));
    chk("skid.data",  dat1, h1.d);
    chk("skid.side",  W'(sid1), W'(h1.s));
    chk("noskid.valid", W'(vld0), W'(q0.size() > 0));
    chk("noskid.count", W'(cnt0), W'(q0.size()));
    chk("noskid.ready", W'(rdy0), W'(er0));
    chk("noskid.data",  dat0, h0.d);
    chk("noskid.side",  W'(sid0), W'(h0.s));
  endtask

  // Advance both models by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic  r1, r0;
    beat_t b;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || out_ready;
    b  = '{d: in_data, s: (in_clr ? S'(0) : in_side)};
    if (flush) begin
      model_clear();
    end else begin
      if ((q1.size() > 0) && out_ready) last1 = q1.pop_front();
      if (in_valid && r1) q1.push_back(b);
      if ((q0.size() > 0) && out_ready) last0 = q0.pop_front();
      if (in_valid && r0) q0.push_back(b);
    end
  endtask

  task automatic apply(input logic f, input logic v, input logic [W-1:0] d,
                       input logic [S-1:0] s, input logic c, input logic r);
    @(negedge clk);
    flush     = f;
    in_valid  = v;
    in_data   = d;
    in_side   = s;
    in_clr    = c;
    out_ready = r;
    #1;
    check_models();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    logic        f, v;
    logic [31:0] d;
    logic [5:0]  s;
    logic        c, r;
    logic        ev;
    logic [1:0]  ec;
    logic        er;
    logic [31:0] ed;
    logic [5:0]  es;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_side = '0; in_clr = 1'b0; out_ready = 1'b0;
    model_clear();

    //         f  v  data       side   c  r   ev ec    er ed         es
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{0, 1, 32'h1,  6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{0, 1, 32'h2,  6'h00, 0, 1,  1, 2'd1, 1, 32'h1,  6'h00});
    tbl.push_back('{0, 1, 32'h3,  6'h00, 0, 1,  1, 2'd1, 1, 32'h2,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  1, 2'd1, 1, 32'h3,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 0,  0, 2'd0, 1, 32'h3,  6'h00});
    tbl.push_back('{0, 1, 32'hA,  6'h00, 0, 0,  0, 2'd0, 1, 32'h3,  6'h00});
    tbl.push_back('{0, 1, 32'hB,  6'h00, 0, 0,  1, 2'd1, 1, 32'hA,  6'h00});
    tbl.push_back('{0, 1, 32'hC,  6'h00, 0, 0,  1, 2'd2, 0, 32'hA,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  1, 2'd2, 0, 32'hA,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  1, 2'd1, 1, 32'hB,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  0, 2'd0, 1, 32'hB,  6'h00});
    tbl.push_back('{0, 1, 32'h11, 6'h2A, 1, 1,  0, 2'd0, 1, 32'hB,  6'h00});
    tbl.push_back('{0, 1, 32'h12, 6'h2A, 0, 1,  1, 2'd1, 1, 32'h11, 6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 0,  1, 2'd1, 1, 32'h12, 6'h2A});
    tbl.push_back('{0, 1, 32'h21, 6'h00, 0, 0,  1, 2'd1, 1, 32'h12, 6'h2A});
    tbl.push_back('{1, 1, 32'h55, 6'h00, 0, 0,  1, 2'd2, 0, 32'h12, 6'h2A});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{1, 1, 32'h66, 6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{0, 1, 32'h77, 6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});
    tbl.push_back('{1, 0, 32'h0,  6'h00, 0, 1,  1, 2'd1, 1, 32'h77, 6'h00});
    tbl.push_back('{0, 0, 32'h0,  6'h00, 0, 1,  0, 2'd0, 1, 32'h0,  6'h00});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table against the skid variant (models check both variants).
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].f, tbl[i].v, W'(tbl[i].d), tbl[i].s, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d.valid", i), W'(vld1), W'(tbl[i].ev));
      chk($sformatf("tbl%0d.count", i), W'(cnt1), W'(tbl[i].ec));
      chk($sformatf("tbl%0d.ready", i), W'(rdy1), W'(tbl[i].er));
      chk($sformatf("tbl%0d.data", i),  dat1, W'(tbl[i].ed));
      chk($sformatf("tbl%0d.side", i),  W'(sid1), W'(tbl[i].es));
      tick();
    end

    // No-skid variant: ready follows out_ready_i combinationally while busy.
    apply(0, 1, W'(32'h31), 6'h00, 0, 0);
    chk("noskid.empty_ready", W'(rdy0), W'(1));
    tick();
    apply(0, 1, W'(32'h32), 6'h00, 0, 0);
    chk("noskid.stalled_ready", W'(rdy0), W'(0));
    chk("noskid.stalled_data",  dat0, W'(32'h31));
    tick();
    apply(0, 1, W'(32'h32), 6'h00, 0, 1);
    chk("noskid.passthru_ready", W'(rdy0), W'(1));
    chk("noskid.passthru_valid", W'(vld0), W'(1));
    tick();
    apply(0, 0, '0, 6'h00, 0, 0);
    chk("noskid.replaced_data",  dat0, W'(32'h32));
    chk("noskid.replaced_count", W'(cnt0), W'(1));
    tick();

    // Fill the skid stage, then assert reset between clock edges.
    apply(0, 1, W'(32'h42), 6'h15, 0, 0);
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst.skid.valid",   W'(vld1), W'(0));
    chk("rst.skid.count",   W'(cnt1), W'(0));
    chk("rst.skid.data",    dat1, W'(0));
    chk("rst.skid.side",    W'(sid1), W'(0));
    chk("rst.skid.ready",   W'(rdy1), W'(1));
    chk("rst.noskid.valid", W'(vld0), W'(0));
    chk("rst.noskid.data",  dat0, W'(0));
    chk("rst.noskid.ready", W'(rdy0), W'(1));
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the FIFO model.
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7,
            {$urandom, $urandom, $urandom, $urandom},
            S'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 6 : 9));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
